// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimator sequencing controller.
package cic_pkg;
    localparam int RATE_W   = 8;
    localparam int MIN_RATE = 2;

    typedef logic [RATE_W-1:0] rate_t;

    typedef enum logic {
        WARMUP  = 1'b0,
        SETTLED = 1'b1
    } ctrl_state_t;

    // Number of decimated outputs that are still polluted by the filter's start-up history
    function automatic int warm_len(input int n, input int m);
        return n * m;
    endfunction
endpackage

// File: rtl/cic_rate_counter.sv
// Input-sample counter: dec is combinational on the last sample of each frame, clr reloads 0.
// Advances only on i_valid; no backpressure, the counter follows the sample strobe.
module cic_rate_counter #(
    parameter int RW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    input  logic [RW-1:0] rate,
    input  logic          clr,
    output logic          dec
);
    logic [RW-1:0] cnt;
    logic [RW-1:0] last;

    // rate is always >= 2, so this never wraps
    assign last = rate - RW'(1);
    assign dec  = i_valid && (cnt == last);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (i_valid) begin
            cnt <= dec ? '0 : cnt + RW'(1);
        end
    end
endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC sequencer: integrator enable (1 cycle), comb enable wave (strobe+1+k), out valid (strobe+N+1).
// Rate register with frame-boundary apply; no backpressure, everything follows i_valid.
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int RW        = 8,
    parameter int R_DEFAULT = 8,
    parameter int N_STAGES  = 3,
    parameter int M         = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_rate_wr,
    input  logic [RW-1:0]       i_rate,
    output logic                o_int_ce,
    output logic [N_STAGES-1:0] o_comb_ce,
    output logic                o_out_valid,
    output logic [RW-1:0]       o_rate,
    output logic                o_rate_ack,
    output logic                o_rate_err,
    output logic                o_settled
);
    localparam int WL = warm_len(N_STAGES, M);
    localparam int WW = (WL > 1) ? $clog2(WL) : 1;

    logic                dec;
    logic                apply;
    logic                wr_ok;
    logic                pending;
    logic [RW-1:0]       pend_rate;
    logic [N_STAGES-1:0] vpipe;
    ctrl_state_t         state;
    ctrl_state_t         state_nx;
    logic [WW-1:0]       warm_cnt;
    logic [WW-1:0]       warm_nx;

    // pending is only visible the cycle after a write, so a write coinciding with dec waits a frame
    assign apply     = dec && pending;
    assign wr_ok     = (i_rate >= RW'(MIN_RATE));
    assign o_settled = (state == SETTLED);

    cic_rate_counter #(.RW(RW)) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .rate    (o_rate),
        .clr     (apply),
        .dec     (dec)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= WARMUP;
            warm_cnt <= '0;
        end else begin
            state    <= state_nx;
            warm_cnt <= warm_nx;
        end
    end

    always_comb begin
        state_nx = state;
        warm_nx  = warm_cnt;
        case (state)
            WARMUP: begin
                if (dec) begin
                    if (warm_cnt == WW'(WL - 1)) begin
                        state_nx = SETTLED;
                        warm_nx  = '0;
                    end else begin
                        warm_nx = warm_cnt + WW'(1);
                    end
                end
            end
            SETTLED: ;
            default: state_nx = WARMUP;
        endcase
        if (apply) begin
            state_nx = WARMUP;
            warm_nx  = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_int_ce    <= 1'b0;
            o_comb_ce   <= '0;
            vpipe       <= '0;
            o_out_valid <= 1'b0;
            o_rate      <= RW'(R_DEFAULT);
            o_rate_ack  <= 1'b0;
            o_rate_err  <= 1'b0;
            pending     <= 1'b0;
            pend_rate   <= '0;
        end else begin
            o_int_ce     <= i_valid;
            o_comb_ce[0] <= dec;
            vpipe[0]     <= dec && (state == SETTLED);
            for (int k = 1; k < N_STAGES; k++) begin
                o_comb_ce[k] <= o_comb_ce[k-1];
                vpipe[k]     <= vpipe[k-1];
            end
            o_out_valid <= o_comb_ce[N_STAGES-1] && vpipe[N_STAGES-1];
            o_rate_ack  <= apply;
            o_rate_err  <= i_rate_wr && !wr_ok;
            if (apply) begin
                o_rate <= pend_rate;
            end
            // a fresh write in the apply cycle becomes the next pending value
            if (i_rate_wr && wr_ok) begin
                pending   <= 1'b1;
                pend_rate <= i_rate;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end
endmodule
